// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding and default vectors.
package mips_pkg;

  localparam int unsigned DATA_SIZE_DEF    = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam int unsigned TIMEOUT_DEF      = 16;

  typedef enum logic [1:0] {
    RESET_HOLD    = 2'd0,
    RUN           = 2'd1,
    REDIRECT_WAIT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_redirect_select.sv
// Priority mux for PC redirects: exception beats branch, branch beats jump.
module redirect_select #(
  parameter int unsigned           DATA_SIZE  = 32,
  parameter logic [DATA_SIZE-1:0]  EXC_VECTOR = 32'h8000_0180
) (
  input  logic                 exception,
  input  logic                 branch_taken,
  input  logic [DATA_SIZE-1:0] branch_target,
  input  logic                 jump,
  input  logic [DATA_SIZE-1:0] jump_target,
  output logic                 valid,
  output logic [DATA_SIZE-1:0] target,
  output logic                 is_exc
);

  always_comb begin
    valid  = exception | branch_taken | jump;
    is_exc = exception;
    if (exception)         target = EXC_VECTOR;
    else if (branch_taken) target = branch_target;
    else                   target = jump_target;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next PC, handshakes with instruction
// memory and parks redirects that arrive while a fetch is outstanding.
//
// state         | meaning
// RESET_HOLD    | one cycle after reset, PC forced to reset_vector
// RUN           | normal fetch: sequential, stall or immediate redirect
// REDIRECT_WAIT | redirect parked until instruction memory answers
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned           data_size      = DATA_SIZE_DEF,
  parameter logic [data_size-1:0]  reset_vector   = RESET_VECTOR_DEF,
  parameter logic [data_size-1:0]  exc_vector     = EXC_VECTOR_DEF,
  parameter int unsigned           timeout_cycles = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_size-1:0] pc_cur,
  input  logic                 hazard_stall,
  input  logic                 branch_taken,
  input  logic [data_size-1:0] branch_target,
  input  logic                 jump,
  input  logic [data_size-1:0] jump_target,
  input  logic                 exception,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic [data_size-1:0] pc_next,
  output logic                 pc_hold,
  output logic                 flush_if_id,
  output logic                 imem_timeout
);

  localparam int unsigned        CW      = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0]      TO_LAST = CW'(timeout_cycles - 1);

  seq_state_e           state_q, state_d;
  logic [data_size-1:0] pend_target_q, pend_target_d;
  logic                 pend_exc_q, pend_exc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 live_valid, live_is_exc;
  logic [data_size-1:0] live_target;
  logic                 pend_valid, pend_is_exc;
  logic [data_size-1:0] pend_target;
  logic                 take_live, timeout_hit;
  logic [data_size-1:0] merged_target;
  logic                 merged_exc;

  redirect_select #(.DATA_SIZE(data_size), .EXC_VECTOR(exc_vector)) u_live_sel (
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .valid         (live_valid),
    .target        (live_target),
    .is_exc        (live_is_exc)
  );

  // The parked redirect re-enters the same mux so exception priority is shared.
  redirect_select #(.DATA_SIZE(data_size), .EXC_VECTOR(exc_vector)) u_pend_sel (
    .exception     (pend_exc_q),
    .branch_taken  (!pend_exc_q && (state_q == REDIRECT_WAIT)),
    .branch_target (pend_target_q),
    .jump          (1'b0),
    .jump_target   ('0),
    .valid         (pend_valid),
    .target        (pend_target),
    .is_exc        (pend_is_exc)
  );

  always_comb begin
    take_live     = live_valid && (live_is_exc || !pend_is_exc || !pend_valid);
    merged_target = take_live ? live_target : pend_target;
    merged_exc    = take_live ? live_is_exc : pend_is_exc;
    timeout_hit   = !imem_ready && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pend_exc_d    = pend_exc_q;
    cnt_d         = cnt_q;
    imem_req      = 1'b0;
    pc_hold       = 1'b1;
    pc_next       = pc_cur;
    flush_if_id   = 1'b0;
    imem_timeout  = 1'b0;

    if (reset) begin
      state_d       = RESET_HOLD;
      pend_target_d = '0;
      pend_exc_d    = 1'b0;
      cnt_d         = '0;
      pc_next       = reset_vector;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          pc_hold = 1'b0;
          pc_next = reset_vector;
          state_d = RUN;
        end
        RUN, REDIRECT_WAIT: begin
          imem_req = 1'b1;
          if (timeout_hit) begin
            imem_timeout  = 1'b1;
            pc_hold       = 1'b0;
            pc_next       = exc_vector;
            flush_if_id   = 1'b1;
            cnt_d         = '0;
            pend_target_d = '0;
            pend_exc_d    = 1'b0;
            state_d       = RUN;
          end else if (imem_ready) begin
            cnt_d = '0;
            if (state_q == REDIRECT_WAIT || live_valid) begin
              pc_hold       = 1'b0;
              pc_next       = (state_q == REDIRECT_WAIT) ? merged_target : live_target;
              flush_if_id   = 1'b1;
              pend_target_d = '0;
              pend_exc_d    = 1'b0;
              state_d       = RUN;
            end else if (!hazard_stall) begin
              pc_hold = 1'b0;
              pc_next = pc_cur + data_size'(4);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            // Memory busy: park the winning redirect until the fetch returns.
            if (state_q == REDIRECT_WAIT || live_valid) begin
              pend_target_d = (state_q == REDIRECT_WAIT) ? merged_target : live_target;
              pend_exc_d    = (state_q == REDIRECT_WAIT) ? merged_exc : live_is_exc;
              state_d       = REDIRECT_WAIT;
            end
          end
        end
        default: state_d = RESET_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RESET_HOLD;
      pend_target_q <= '0;
      pend_exc_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      pend_exc_q    <= pend_exc_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a behavioural fetch model.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        hazard_stall, branch_taken, jump, exception, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, pc_hold, flush_if_id, imem_timeout;
  logic [31:0] pc_next;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .data_size(32), .reset_vector(RV), .exc_vector(EXC), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .exception(exception), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc_next(pc_next), .pc_hold(pc_hold),
    .flush_if_id(flush_if_id), .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = just out of reset, 1 = fetching, 2 = redirect parked
  int          m_mode, n_mode;
  logic [31:0] m_pend, n_pend;
  bit          m_pend_exc, n_pend_exc;
  int          m_busy, n_busy;
  logic        e_req, e_hold, e_flush, e_to;
  logic [31:0] e_next;

  task automatic model_eval();
    bit          want;
    logic [31:0] want_t;
    bit          want_x;
    e_req = 0; e_hold = 1; e_flush = 0; e_to = 0; e_next = pc_cur;
    n_mode = m_mode; n_pend = m_pend; n_pend_exc = m_pend_exc; n_busy = m_busy;
    if (reset) begin
      e_next = RV; n_mode = 0; n_pend = 0; n_pend_exc = 0; n_busy = 0;
    end else if (m_mode == 0) begin
      e_hold = 0; e_next = RV; n_mode = 1;
    end else begin
      e_req  = 1;
      want   = exception || branch_taken || jump;
      want_t = exception ? EXC : (branch_taken ? branch_target : jump_target);
      want_x = exception;
      if (m_mode == 2) begin
        if (!(want && (exception || !m_pend_exc))) begin
          want_t = m_pend; want_x = m_pend_exc;
        end
        want = 1;
      end
      if (!imem_ready && m_busy + 1 == TO) begin
        e_to = 1; e_hold = 0; e_next = EXC; e_flush = 1;
        n_busy = 0; n_mode = 1; n_pend = 0; n_pend_exc = 0;
      end else if (imem_ready) begin
        n_busy = 0;
        if (want) begin
          e_hold = 0; e_next = want_t; e_flush = 1;
          n_mode = 1; n_pend = 0; n_pend_exc = 0;
        end else if (!hazard_stall) begin
          e_hold = 0; e_next = pc_cur + 32'd4;
        end
      end else begin
        n_busy = m_busy + 1;
        if (want) begin
          n_mode = 2; n_pend = want_t; n_pend_exc = want_x;
        end
      end
    end
  endtask

  function automatic logic [35:0] obs_vec();
    return {imem_req, pc_hold, flush_if_id, imem_timeout, e_hold ? 32'h0 : pc_next};
  endfunction

  function automatic logic [35:0] exp_vec();
    return {e_req, e_hold, e_flush, e_to, e_hold ? 32'h0 : e_next};
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    m_mode = n_mode; m_pend = n_pend; m_pend_exc = n_pend_exc; m_busy = n_busy;
    @(negedge clk);
    if (!e_hold) pc_cur = e_next;
    branch_taken = 0; jump = 0; exception = 0;
  endtask

  task automatic idle_inputs();
    reset = 0; hazard_stall = 0; branch_taken = 0; jump = 0; exception = 0;
    imem_ready = 1; branch_target = 0; jump_target = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; pc_cur = 32'h40;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (pc_hold !== 1'b1 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got hold=%b req=%b want hold=1 req=0", i, pc_hold, imem_req);
      end
      advance();
    end
    reset = 0;
    settle();
    n_checks++;
    if (pc_next !== 32'h0 || pc_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got next=%h hold=%b want next=0 hold=0", pc_next, pc_hold);
    end
    advance();
    for (int i = 1; i <= 2; i++) begin
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec() || pc_next !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL reset_seq cyc%0d got %h next=%h want %h next=%h", i, obs_vec(), pc_next, exp_vec(), 32'(4 * i));
      end
      advance();
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    pc_cur = 32'h100;
    for (int i = 0; i < 3; i++) begin
      hazard_stall = (i < 2);
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec() || pc_hold !== (i < 2)) begin
        n_fail++;
        $display("FAIL stall cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if (pc_next !== 32'h104) begin
          n_fail++;
          $display("FAIL stall_release got next=%h want 00000104", pc_next);
        end
      end
      advance();
    end
  endtask

  task automatic test_branch_busy();
    idle_inputs();
    pc_cur = 32'h180;
    for (int i = 0; i < 5; i++) begin
      imem_ready   = (i >= 3);
      branch_taken = (i == 0);
      branch_target = 32'h200;
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL branch_busy cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (flush_if_id !== (i == 3)) begin
        n_fail++;
        $display("FAIL branch_flush cyc%0d got %b want %b", i, flush_if_id, (i == 3));
      end
      if (i == 3) begin
        n_checks++;
        if (pc_next !== 32'h200 || pc_hold !== 1'b0) begin
          n_fail++;
          $display("FAIL branch_apply got next=%h hold=%b want 00000200 hold=0", pc_next, pc_hold);
        end
      end
      advance();
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    exception = 1; branch_taken = 1; branch_target = 32'h300; hazard_stall = 1;
    settle();
    n_checks++;
    if (pc_next !== EXC || flush_if_id !== 1'b1 || pc_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL priority got next=%h flush=%b hold=%b want %h 1 0", pc_next, flush_if_id, pc_hold, EXC);
    end
    advance();
    hazard_stall = 0;
    for (int i = 0; i < 3; i++) begin
      imem_ready  = (i == 2);
      exception   = (i == 0);
      jump        = (i == 1);
      jump_target = 32'h600;
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pend_exc cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if (pc_next !== EXC || flush_if_id !== 1'b1) begin
          n_fail++;
          $display("FAIL pend_exc_apply got next=%h flush=%b want %h 1", pc_next, flush_if_id, EXC);
        end
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    idle_inputs();
    settle();
    advance();
    imem_ready = 0;
    for (int i = 1; i <= TO + 1; i++) begin
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec() || imem_timeout !== (i == TO)) begin
        n_fail++;
        $display("FAIL timeout cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == TO) begin
        n_checks++;
        if (pc_next !== EXC || pc_hold !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_vec got next=%h hold=%b want %h 0", pc_next, pc_hold, EXC);
        end
      end
      advance();
    end
    imem_ready = 1;
    settle();
    advance();
  endtask

  task automatic test_wrap_reset();
    idle_inputs();
    pc_cur = 32'hFFFF_FFFC;
    settle();
    n_checks++;
    if (pc_next !== 32'h0 || pc_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got next=%h hold=%b want 00000000 0", pc_next, pc_hold);
    end
    advance();
    imem_ready = 0; branch_taken = 1; branch_target = 32'h500;
    settle();
    advance();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin reset = 0; imem_ready = 1; end
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_reset cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if (pc_next !== RV || pc_hold !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_reset_vec got next=%h hold=%b want %h 0", pc_next, pc_hold, RV);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (flush_if_id !== 1'b0 || pc_next === 32'h500) begin
          n_fail++;
          $display("FAIL mid_reset_drop got next=%h flush=%b want pending dropped", pc_next, flush_if_id);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 99) < 3);
      exception     = ($urandom_range(0, 99) < 5);
      branch_taken  = ($urandom_range(0, 99) < 15);
      jump          = ($urandom_range(0, 99) < 10);
      hazard_stall  = ($urandom_range(0, 99) < 20);
      imem_ready    = ($urandom_range(0, 99) < 65);
      branch_target = $urandom;
      jump_target   = $urandom;
      if ($urandom_range(0, 99) < 5) pc_cur = 32'hFFFF_FFFC;
      settle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    m_mode = 0; m_pend = 0; m_pend_exc = 0; m_busy = 0;
    pc_cur = 0;
    idle_inputs();
    test_reset();
    test_stall();
    test_branch_busy();
    test_priority();
    test_timeout();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
